// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input debouncer:
//   deb_state_t              - per-channel debounce FSM states
//   DEFAULT_DEBOUNCE_CYCLES  - production qualification length (10 ms @ 100 MHz)
//   SIM_DEBOUNCE_CYCLES      - short qualification length for benches
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } deb_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One channel of the debouncer: two-flop synchronizer, debounce FSM with
// qualification counter, registered clean level and optional edge pulses.
//
// Optional feature macro: DEBOUNCE_EDGE_EN
//   defined   - rise/fall are registered one-cycle pulses on clean transitions
//   undefined - no edge registers are built; rise/fall are tied low
//
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   asynchronous active-high reset
//   raw    in   unsynchronized switch/button level
//   clean  out  debounced level, registered
//   rise   out  one-cycle pulse on clean 0->1
//   fall   out  one-cycle pulse on clean 1->0
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES   // must be >= 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   // DEBOUNCE_CYCLES-1 always fits in $clog2(DEBOUNCE_CYCLES) bits, so the
   // counter saturates at the terminal count and never wraps.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_reg;
   logic             sync2_reg;
   deb_state_t       state_reg,  state_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;
   logic             clean_reg,  clean_next;

   // Synchronizer: only sync2_reg is allowed to feed the FSM.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= STABLE_LO;
         cnt_reg   <= '0;
         clean_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         clean_reg <= clean_next;
      end
   end

   // Entering a WAIT state already counts the first differing sample, which is
   // why the counter starts at 1 and the flip happens at DEBOUNCE_CYCLES-1.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      clean_next = clean_reg;
      case (state_reg)
         STABLE_LO: begin
            if (sync2_reg) begin
               state_next = WAIT_HI;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         WAIT_HI: begin
            if (!sync2_reg) begin
               state_next = STABLE_LO;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = STABLE_HI;
               clean_next = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!sync2_reg) begin
               state_next = WAIT_LO;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         WAIT_LO: begin
            if (sync2_reg) begin
               state_next = STABLE_HI;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = STABLE_LO;
               clean_next = 1'b0;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = STABLE_LO;
            cnt_next   = '0;
            clean_next = 1'b0;
         end
      endcase
   end

   assign clean = clean_reg;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_reg, rise_next;
   logic fall_reg, fall_next;

   // clean only changes on a completed qualification, so a change between
   // clean_reg and clean_next is exactly the transition to pulse on.
   always_comb begin
      rise_next = ~clean_reg &  clean_next;
      fall_next =  clean_reg & ~clean_next;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         rise_reg <= rise_next;
         fall_reg <= fall_next;
      end
   end

   assign rise = rise_reg;
   assign fall = fall_reg;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// N independent synchronizer + debouncer channels for board switches and
// pushbuttons. Clean outputs are safe to use as data or clock enables
// downstream.
//
// Optional feature macro: DEBOUNCE_EDGE_EN (edge pulses on Rise/Fall; when
// undefined Rise and Fall are constant 0 and Clean timing is unchanged).
//
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   asynchronous active-high reset
//   Raw    in   [N-1:0] unsynchronized input levels
//   Clean  out  [N-1:0] debounced levels, registered
//   Rise   out  [N-1:0] one-cycle pulse on Clean 0->1
//   Fall   out  [N-1:0] one-cycle pulse on Clean 1->0
// -----------------------------------------------------------------------------
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES   // must be >= 2
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [N-1:0] Raw,
   output logic [N-1:0] Clean,
   output logic [N-1:0] Rise,
   output logic [N-1:0] Fall
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .Clk   (Clk),
            .Reset (Reset),
            .raw   (Raw[gi]),
            .clean (Clean[gi]),
            .rise  (Rise[gi]),
            .fall  (Fall[gi])
         );
      end
   endgenerate

endmodule
